// File: rtl/float_addsub_pipe.sv
// float_addsub_pipe
//   Three-stage pipelined floating-point adder/subtractor, {sign, exp, mant}
//   format with parametrised field widths, round-to-nearest-even, DAZ/FTZ,
//   overflow saturation and a tag carried alongside each operation.
//
//   Stage 1: unpack, order by magnitude, align smaller operand (G/R/S).
//   Stage 2: magnitude add/subtract, leading-zero count.
//   Stage 3: normalise, round, exponent range checks, pack (output register).
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake
//   in_a, in_b        operands
//   in_sub            1: a-b, 0: a+b
//   in_tag            sideband ID travelling with the operation
//   out_valid/out_ready result handshake
//   out_result        rounded result
//   out_tag           tag of out_result
//   out_flags         {invalid, overflow, underflow, inexact}
//
// Build option
//   FP_ADDSUB_SPECIALS_EN: decode all-ones exponents as Inf/NaN. When not
//   defined they are ordinary finite values and invalid is always 0.

module float_addsub_pipe #(
  parameter int unsigned EXPO_WIDTH = 8,
  parameter int unsigned MANT_WIDTH = 23,
  parameter int unsigned DATA_WIDTH = 1 + EXPO_WIDTH + MANT_WIDTH,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_sub,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [3:0]            out_flags
);

  localparam int unsigned ALN_W = MANT_WIDTH + 4;          // hidden+mant+G+R+S
  localparam int unsigned SUM_W = MANT_WIDTH + 5;          // plus carry
  localparam int unsigned LZC_W = $clog2(SUM_W + 1);
  localparam int unsigned EXT_W = EXPO_WIDTH + 2;          // signed exponent
  localparam logic signed [EXT_W-1:0] EMAX = {2'b00, {EXPO_WIDTH{1'b1}}};

  // Flow control: a stage can load when empty or when its successor loads.
  logic rdy1, rdy2, rdy3;
  logic s1_valid_q, s2_valid_q, s3_valid_q;

  assign rdy3     = !s3_valid_q || out_ready;
  assign rdy2     = !s2_valid_q || rdy3;
  assign rdy1     = !s1_valid_q || rdy2;
  assign in_ready = rdy1;

  // ---------------------------------------------------------------- stage 1
  logic                  a_sign, b_sign, swap, l_sign;
  logic [EXPO_WIDTH-1:0] a_exp, b_exp, l_exp, s_exp, diff;
  logic [MANT_WIDTH-1:0] a_man, b_man;
  logic [DATA_WIDTH-2:0] a_mag, b_mag;
  logic [MANT_WIDTH:0]   l_frac, s_frac;
  logic [MANT_WIDTH+2:0] s_ext, s_align;
  logic [31:0]           diff32;
  logic                  s_sticky;

  logic                  s1_sign_d, s1_sub_d, s1_spec_d, s1_inv_d;
  logic [EXPO_WIDTH-1:0] s1_exp_d;
  logic [ALN_W-1:0]      s1_mant_l_d, s1_mant_s_d;
  logic [DATA_WIDTH-1:0] s1_spec_res_d;

  logic                  s1_sign_q, s1_sub_q, s1_spec_q, s1_inv_q;
  logic [EXPO_WIDTH-1:0] s1_exp_q;
  logic [ALN_W-1:0]      s1_mant_l_q, s1_mant_s_q;
  logic [DATA_WIDTH-1:0] s1_spec_res_q;
  logic [TAG_WIDTH-1:0]  s1_tag_q;

`ifdef FP_ADDSUB_SPECIALS_EN
  localparam logic [DATA_WIDTH-1:0] QNAN =
    {1'b0, {EXPO_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
  logic a_top, b_top, a_nan, b_nan;
`endif

  always_comb begin
    a_sign = in_a[DATA_WIDTH-1];
    b_sign = in_b[DATA_WIDTH-1] ^ in_sub;
    a_exp  = in_a[DATA_WIDTH-2 -: EXPO_WIDTH];
    b_exp  = in_b[DATA_WIDTH-2 -: EXPO_WIDTH];
    a_man  = in_a[MANT_WIDTH-1:0];
    b_man  = in_b[MANT_WIDTH-1:0];

    // Denormal inputs collapse to zero before ordering.
    a_mag  = (a_exp == '0) ? '0 : in_a[DATA_WIDTH-2:0];
    b_mag  = (b_exp == '0) ? '0 : in_b[DATA_WIDTH-2:0];
    swap   = b_mag > a_mag;

    l_sign = swap ? b_sign : a_sign;
    l_exp  = swap ? b_exp : a_exp;
    s_exp  = swap ? a_exp : b_exp;
    l_frac = (l_exp == '0) ? '0 : {1'b1, (swap ? b_man : a_man)};
    s_frac = (s_exp == '0) ? '0 : {1'b1, (swap ? a_man : b_man)};

    diff     = l_exp - s_exp;
    diff32   = 32'(diff);
    s_ext    = {s_frac, 2'b00};
    s_sticky = 1'b0;
    s_align  = '0;
    if (diff32 >= 32'(MANT_WIDTH + 3)) begin
      s_sticky = |s_frac;
    end else begin
      s_align = s_ext >> diff32;
      for (int unsigned i = 0; i < MANT_WIDTH + 3; i++) begin
        if (i < diff32) s_sticky = s_sticky | s_ext[i];
      end
    end

    s1_sign_d   = l_sign;
    s1_sub_d    = a_sign ^ b_sign;
    s1_exp_d    = l_exp;
    s1_mant_l_d = {l_frac, 3'b000};
    s1_mant_s_d = {s_align, s_sticky};

    s1_spec_d     = 1'b0;
    s1_inv_d      = 1'b0;
    s1_spec_res_d = '0;
`ifdef FP_ADDSUB_SPECIALS_EN
    a_top = &a_exp;
    b_top = &b_exp;
    a_nan = a_top && (a_man != '0);
    b_nan = b_top && (b_man != '0);
    s1_spec_d = a_top || b_top;
    if (a_nan || b_nan) begin
      s1_spec_res_d = QNAN;
    end else if (a_top && b_top) begin
      if (a_sign != b_sign) begin
        s1_spec_res_d = QNAN;
        s1_inv_d      = 1'b1;
      end else begin
        s1_spec_res_d = {a_sign, {EXPO_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      end
    end else if (a_top) begin
      s1_spec_res_d = {a_sign, {EXPO_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    end else begin
      s1_spec_res_d = {b_sign, {EXPO_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    end
`endif
  end

  // ---------------------------------------------------------------- stage 2
  logic [SUM_W-1:0]      s2_sum_d;
  logic [LZC_W-1:0]      s2_lzc_d;

  logic                  s2_sign_q, s2_sub_q, s2_spec_q, s2_inv_q;
  logic [EXPO_WIDTH-1:0] s2_exp_q;
  logic [SUM_W-1:0]      s2_sum_q;
  logic [LZC_W-1:0]      s2_lzc_q;
  logic [DATA_WIDTH-1:0] s2_spec_res_q;
  logic [TAG_WIDTH-1:0]  s2_tag_q;

  always_comb begin
    // Ordering guarantees the large aligned magnitude is never below the small.
    if (s1_sub_q) s2_sum_d = {1'b0, s1_mant_l_q} - {1'b0, s1_mant_s_q};
    else          s2_sum_d = {1'b0, s1_mant_l_q} + {1'b0, s1_mant_s_q};

    s2_lzc_d = LZC_W'(SUM_W);
    for (int unsigned i = 0; i < SUM_W; i++) begin
      if (s2_sum_d[i]) s2_lzc_d = LZC_W'(SUM_W - 1 - i);
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [LZC_W-1:0]        sh;
  logic [SUM_W-2:0]        norm;
  logic signed [EXT_W-1:0] en, ef;
  logic [MANT_WIDTH:0]     mant;
  logic [MANT_WIDTH+1:0]   mant_r;
  logic [MANT_WIDTH-1:0]   frac;
  logic                    g_bit, r_bit, s_bit, rnd_up, inexact;
  logic [DATA_WIDTH-1:0]   s3_result_d;
  logic [3:0]              s3_flags_d;

  logic [DATA_WIDTH-1:0]   s3_result_q;
  logic [TAG_WIDTH-1:0]    s3_tag_q;
  logic [3:0]              s3_flags_q;

  always_comb begin
    sh = s2_lzc_q - LZC_W'(1);
    // Leading one ends up at bit SUM_W-2; the right shift folds the lost bit
    // into sticky.
    if (s2_sum_q[SUM_W-1]) begin
      norm = {s2_sum_q[SUM_W-1:2], |s2_sum_q[1:0]};
      en   = {2'b00, s2_exp_q} + EXT_W'(1);
    end else begin
      norm = (SUM_W-1)'(s2_sum_q << sh);
      en   = {2'b00, s2_exp_q} - EXT_W'(sh);
    end

    mant    = norm[SUM_W-2:3];
    g_bit   = norm[2];
    r_bit   = norm[1];
    s_bit   = norm[0];
    inexact = g_bit | r_bit | s_bit;
    rnd_up  = g_bit & (r_bit | s_bit | mant[0]);
    mant_r  = {1'b0, mant} + (MANT_WIDTH+2)'(rnd_up);

    if (mant_r[MANT_WIDTH+1]) begin
      frac = mant_r[MANT_WIDTH:1];
      ef   = en + EXT_W'(1);
    end else begin
      frac = mant_r[MANT_WIDTH-1:0];
      ef   = en;
    end

    if (s2_spec_q) begin
      s3_result_d = s2_spec_res_q;
      s3_flags_d  = {s2_inv_q, 3'b000};
    end else if (s2_sum_q == '0) begin
      // Exact cancellation yields +0; like-signed zeros keep their sign.
      s3_result_d = {(s2_sub_q ? 1'b0 : s2_sign_q), {(DATA_WIDTH-1){1'b0}}};
      s3_flags_d  = 4'b0000;
    end else if (ef >= EMAX) begin
      s3_result_d = {s2_sign_q, {EXPO_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      s3_flags_d  = 4'b0101;
    end else if (ef[EXT_W-1] || ef == '0) begin
      s3_result_d = {s2_sign_q, {(DATA_WIDTH-1){1'b0}}};
      s3_flags_d  = 4'b0011;
    end else begin
      s3_result_d = {s2_sign_q, ef[EXPO_WIDTH-1:0], frac};
      s3_flags_d  = {3'b000, inexact};
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_inv_q      <= 1'b0;
      s1_exp_q      <= '0;
      s1_mant_l_q   <= '0;
      s1_mant_s_q   <= '0;
      s1_spec_res_q <= '0;
      s1_tag_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_sub_q      <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_inv_q      <= 1'b0;
      s2_exp_q      <= '0;
      s2_sum_q      <= '0;
      s2_lzc_q      <= '0;
      s2_spec_res_q <= '0;
      s2_tag_q      <= '0;
      s3_valid_q    <= 1'b0;
      s3_result_q   <= '0;
      s3_tag_q      <= '0;
      s3_flags_q    <= '0;
    end else begin
      if (rdy1) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_sign_q     <= s1_sign_d;
          s1_sub_q      <= s1_sub_d;
          s1_spec_q     <= s1_spec_d;
          s1_inv_q      <= s1_inv_d;
          s1_exp_q      <= s1_exp_d;
          s1_mant_l_q   <= s1_mant_l_d;
          s1_mant_s_q   <= s1_mant_s_d;
          s1_spec_res_q <= s1_spec_res_d;
          s1_tag_q      <= in_tag;
        end
      end
      if (rdy2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_sign_q     <= s1_sign_q;
          s2_sub_q      <= s1_sub_q;
          s2_spec_q     <= s1_spec_q;
          s2_inv_q      <= s1_inv_q;
          s2_exp_q      <= s1_exp_q;
          s2_sum_q      <= s2_sum_d;
          s2_lzc_q      <= s2_lzc_d;
          s2_spec_res_q <= s1_spec_res_q;
          s2_tag_q      <= s1_tag_q;
        end
      end
      if (rdy3) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          s3_result_q <= s3_result_d;
          s3_tag_q    <= s2_tag_q;
          s3_flags_q  <= s3_flags_d;
        end
      end
    end
  end

  assign out_valid  = s3_valid_q;
  assign out_result = s3_result_q;
  assign out_tag    = s3_tag_q;
  assign out_flags  = s3_flags_q;

endmodule

// File: tb/tb_float_addsub_pipe.sv
module tb_float_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        in_sub;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  float_addsub_pipe #(
    .EXPO_WIDTH(8),
    .MANT_WIDTH(23),
    .TAG_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  // Drives one operation into an idle pipe and waits (bounded) for its result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [3:0] t, output logic [31:0] r,
                        output logic [3:0] f, output logic [3:0] tg, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = s; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    r = out_result; f = out_flags; tg = out_tag;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (out_result !== 32'h0) begin fails++; $display("FAIL reset_out_result: got %h expected 00000000", out_result); end
    tests++; if (out_tag !== 4'h0) begin fails++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    tests++; if (out_flags !== 4'h0) begin fails++; $display("FAIL reset_out_flags: got %b expected 0000", out_flags); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    string       nm[6] = '{"add_1_2", "sub_equal", "negzero", "daz", "sub_3_1", "neg2_plus1"};
    logic [31:0] va[6] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00400000, 32'h40400000, 32'hC0000000};
    logic [31:0] vb[6] = '{32'h40000000, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    logic        vs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] vr[6] = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h3F800000, 32'h40000000, 32'hBF800000};
    logic [31:0] r; logic [3:0] f, tg; int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vs[i], 4'(i + 3), r, f, tg, lat);
      tests++; if (lat != 3) begin fails++; $display("FAIL %s_latency: got %0d expected 3", nm[i], lat); end
      tests++; if (r !== vr[i]) begin fails++; $display("FAIL %s_result: got %h expected %h", nm[i], r, vr[i]); end
      tests++; if (f !== 4'b0000) begin fails++; $display("FAIL %s_flags: got %b expected 0000", nm[i], f); end
      tests++; if (tg !== 4'(i + 3)) begin fails++; $display("FAIL %s_tag: got %h expected %h", nm[i], tg, 4'(i + 3)); end
    end
  endtask

  task automatic test_rne();
    string       nm[4] = '{"rne_tie_even", "rne_tie_odd", "rne_above_half", "sticky_far"};
    logic [31:0] va[4] = '{32'h3F800000, 32'h3F800001, 32'h3F800000, 32'h3F800000};
    logic [31:0] vb[4] = '{32'h33800000, 32'h33800000, 32'h33C00000, 32'h00800000};
    logic [31:0] vr[4] = '{32'h3F800000, 32'h3F800002, 32'h3F800001, 32'h3F800000};
    logic [31:0] r; logic [3:0] f, tg; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], 1'b0, 4'(i), r, f, tg, lat);
      tests++; if (r !== vr[i]) begin fails++; $display("FAIL %s_result: got %h expected %h", nm[i], r, vr[i]); end
      tests++; if (f !== 4'b0001) begin fails++; $display("FAIL %s_flags: got %b expected 0001", nm[i], f); end
    end
  endtask

  task automatic test_exceptions();
    string       nm[4] = '{"overflow_pos", "overflow_neg", "underflow_pos", "underflow_neg"};
    logic [31:0] va[4] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00800001, 32'h80800001};
    logic [31:0] vb[4] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00800000, 32'h80800000};
    logic        vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] vr[4] = '{32'h7F800000, 32'hFF800000, 32'h00000000, 32'h80000000};
    logic [3:0]  vf[4] = '{4'b0101, 4'b0101, 4'b0011, 4'b0011};
    logic [31:0] r; logic [3:0] f, tg; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vs[i], 4'(i), r, f, tg, lat);
      tests++; if (r !== vr[i]) begin fails++; $display("FAIL %s_result: got %h expected %h", nm[i], r, vr[i]); end
      tests++; if (f !== vf[i]) begin fails++; $display("FAIL %s_flags: got %b expected %b", nm[i], f, vf[i]); end
    end
  endtask

  // All-ones exponent operands: Inf/NaN when specials are built in,
  // ordinary large finite values otherwise.
  task automatic test_specials();
    string       nm[3] = '{"inf_plus_one", "inf_minus_inf", "nan_plus_one"};
    logic [31:0] va[3] = '{32'h7F800000, 32'h7F800000, 32'h7FC00001};
    logic [31:0] vb[3] = '{32'h3F800000, 32'hFF800000, 32'h3F800000};
`ifdef FP_ADDSUB_SPECIALS_EN
    logic [31:0] vr[3] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000};
    logic [3:0]  vf[3] = '{4'b0000, 4'b1000, 4'b0000};
`else
    logic [31:0] vr[3] = '{32'h7F800000, 32'h00000000, 32'h7F800000};
    logic [3:0]  vf[3] = '{4'b0101, 4'b0000, 4'b0101};
`endif
    logic [31:0] r; logic [3:0] f, tg; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 1'b0, 4'(i), r, f, tg, lat);
      tests++; if (r !== vr[i]) begin fails++; $display("FAIL %s_result: got %h expected %h", nm[i], r, vr[i]); end
      tests++; if (f !== vf[i]) begin fails++; $display("FAIL %s_flags: got %b expected %b", nm[i], f, vf[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va[4] = '{32'h3F800000, 32'h3F800000, 32'h40400000, 32'hC0000000};
    logic [31:0] vb[4] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    logic        vs[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] vr[4] = '{32'h40400000, 32'h00000000, 32'h40000000, 32'hBF800000};
    int rcv = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid && rcv < 4) begin
        tests++; if (c != rcv + 3) begin fails++; $display("FAIL b2b_timing: got cycle %0d expected %0d", c, rcv + 3); end
        tests++; if (out_result !== vr[rcv]) begin fails++; $display("FAIL b2b_result: got %h expected %h", out_result, vr[rcv]); end
        tests++; if (out_tag !== 4'(rcv)) begin fails++; $display("FAIL b2b_tag: got %h expected %h", out_tag, 4'(rcv)); end
        rcv++;
      end
      if (c < 4) begin
        in_valid = 1'b1; in_a = va[c]; in_b = vb[c]; in_sub = vs[c]; in_tag = 4'(c);
      end else begin
        in_valid = 1'b0;
      end
    end
    tests++; if (rcv != 4) begin fails++; $display("FAIL b2b_count: got %0d expected 4", rcv); end
  endtask

  task automatic test_backpressure();
    int sent = 0, rcv = 0, held = 0;
    logic saw_full = 1'b0, prev_stall = 1'b0, exp_rdy;
    logic [31:0] prev_res, exp_res[9];
    logic [3:0]  prev_tag, prev_flags;
    logic [31:0] fl[10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                            32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h0};
    prev_res = '0; prev_tag = '0; prev_flags = '0;
    for (int i = 0; i < 9; i++) exp_res[i] = fl[i + 1];
    for (int c = 0; c < 60 && rcv < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 7);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_a = fl[sent]; in_b = 32'h3F800000; in_sub = 1'b0; in_tag = 4'(sent);
      end
      #1;
      if (prev_stall) begin
        tests++;
        if (out_valid !== 1'b1 || out_result !== prev_res || out_tag !== prev_tag || out_flags !== prev_flags) begin
          fails++;
          $display("FAIL bp_stable: got v=%b %h/%h/%b expected v=1 %h/%h/%b", out_valid, out_result, out_tag, out_flags, prev_res, prev_tag, prev_flags);
        end
      end
      exp_rdy = (held < 3) || out_ready;
      tests++; if (in_ready !== exp_rdy) begin fails++; $display("FAIL bp_in_ready: cycle %0d got %b expected %b", c, in_ready, exp_rdy); end
      if (held == 3 && !out_ready) saw_full = 1'b1;
      if (out_valid && out_ready) begin
        tests++; if (out_tag !== 4'(rcv)) begin fails++; $display("FAIL bp_tag: got %h expected %h", out_tag, 4'(rcv)); end
        tests++; if (out_result !== exp_res[rcv]) begin fails++; $display("FAIL bp_result: got %h expected %h", out_result, exp_res[rcv]); end
        tests++; if (out_flags !== 4'b0000) begin fails++; $display("FAIL bp_flags: got %b expected 0000", out_flags); end
        rcv++; held--;
      end
      if (in_valid && in_ready) begin sent++; held++; end
      prev_stall = out_valid && !out_ready;
      prev_res = out_result; prev_tag = out_tag; prev_flags = out_flags;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    tests++; if (rcv != 8) begin fails++; $display("FAIL bp_count: got %0d expected 8", rcv); end
    tests++; if (saw_full !== 1'b1) begin fails++; $display("FAIL bp_full: got %b expected 1", saw_full); end
    repeat (4) @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_extra: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_sub = 1'b0; in_tag = 4'hA;
    @(negedge clk);
    in_a = 32'h40400000; in_b = 32'h3F800000; in_tag = 4'hB;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
    tests++; if (out_result !== 32'h0 || out_tag !== 4'h0 || out_flags !== 4'h0) begin
      fails++; $display("FAIL rst_mid_outputs: got %h/%h/%b expected 00000000/0/0000", out_result, out_tag, out_flags);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_partial: cycle %0d got %b expected 0", c, out_valid); end
    end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rne();
    test_exceptions();
    test_specials();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
